// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch front-end. Issues aligned BUS_WIDTH reads to instruction
//   memory (one outstanding at a time), splits each returned beat into one or
//   two instructions and buffers {pc, instr} pairs in a small FIFO that is
//   presented to decode through a valid/ready handshake. A redirect from
//   execute flushes the FIFO and discards any in-flight response.
//
//   Optional feature macro: FETCH_HALT_ON_ECALL_EN
//     When defined, pushing an ecall/ebreak word (opcode 7'b1110011) stops
//     fetch: the later word of that beat is dropped and no further requests
//     are issued until the next redirect.
//
// Ports
//   clk             rising-edge clock
//   reset_n         synchronous active-low reset
//   redirect_valid  1-cycle pulse: restart fetch at redirect_pc
//   redirect_pc     new PC (bits [1:0] forced to 0)
//   mem_req_valid   read request valid
//   mem_req_addr    8-byte-aligned read address
//   mem_req_ready   memory accepts the request
//   mem_resp_valid  read data valid (responses return in request order)
//   mem_resp_data   [31:0] instr at addr, [63:32] instr at addr+4
//   instr_valid     FIFO head valid
//   instr           FIFO head instruction
//   instr_pc        PC of the FIFO head instruction
//   instr_ready     decoder consumes head when instr_valid & instr_ready
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int                    ADDR_WIDTH  = 64,
  parameter int                    INSTR_WIDTH = 32,
  parameter int                    BUS_WIDTH   = 64,
  parameter int                    FIFO_DEPTH  = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   mem_req_valid,
  output logic [ADDR_WIDTH-1:0]  mem_req_addr,
  input  logic                   mem_req_ready,
  input  logic                   mem_resp_valid,
  input  logic [BUS_WIDTH-1:0]   mem_resp_data,
  output logic                   instr_valid,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]  instr_pc,
  input  logic                   instr_ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

`ifdef FETCH_HALT_ON_ECALL_EN
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN} state_t;
`endif

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   pc_reg, pc_next;
  logic [CNT_W-1:0]        count_reg, count_next, free_next;
  logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic                    mem_req_valid_reg, req_next;
  logic [ADDR_WIDTH-1:0]   mem_req_addr_reg;
  logic [INSTR_WIDTH-1:0]  hold_instr_reg;
  logic [ADDR_WIDTH-1:0]   hold_pc_reg;

  logic [INSTR_WIDTH-1:0]  data_mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]   pc_mem   [FIFO_DEPTH];

  logic                    handshake, pop;
  logic [1:0]              push_cnt;
  logic [INSTR_WIDTH-1:0]  word0, word1, lo_word, hi_word;
  logic [ADDR_WIDTH-1:0]   word0_pc, word1_pc, line_addr, hi_pc;
  logic [PTR_W-1:0]        wr_ptr_plus1;

  assign line_addr    = pc_reg & ~ADDR_WIDTH'(7);
  assign hi_pc        = line_addr + ADDR_WIDTH'(4);
  assign lo_word      = mem_resp_data[INSTR_WIDTH-1:0];
  assign hi_word      = mem_resp_data[2*INSTR_WIDTH-1:INSTR_WIDTH];
  assign handshake    = mem_req_valid_reg & mem_req_ready;
  assign instr_valid  = (count_reg != '0);
  assign pop          = instr_valid & instr_ready;
  assign wr_ptr_plus1 = wr_ptr_reg + PTR_W'(1);

  // Head is read straight from the entry registers; when empty the last
  // value seen by the decoder is held.
  assign instr         = instr_valid ? data_mem[rd_ptr_reg] : hold_instr_reg;
  assign instr_pc      = instr_valid ? pc_mem[rd_ptr_reg]   : hold_pc_reg;
  assign mem_req_valid = mem_req_valid_reg;
  assign mem_req_addr  = mem_req_addr_reg;

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    push_cnt   = 2'd0;
    word0      = lo_word;
    word0_pc   = line_addr;
    word1      = hi_word;
    word1_pc   = hi_pc;

    case (state_reg)
      S_REQ: begin
        if (handshake) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          pc_next    = line_addr + ADDR_WIDTH'(8);
          state_next = S_REQ;
          if (!pc_reg[2]) begin
            push_cnt = 2'd2;
`ifdef FETCH_HALT_ON_ECALL_EN
            if (lo_word[6:0] == OPC_SYSTEM) begin
              push_cnt   = 2'd1;
              state_next = S_HALT;
            end else if (hi_word[6:0] == OPC_SYSTEM) begin
              state_next = S_HALT;
            end
`endif
          end else begin
            // Entered mid-beat: only the upper word belongs to the stream.
            word0    = hi_word;
            word0_pc = hi_pc;
            push_cnt = 2'd1;
`ifdef FETCH_HALT_ON_ECALL_EN
            if (hi_word[6:0] == OPC_SYSTEM) state_next = S_HALT;
`endif
          end
        end
      end
      S_DRAIN: begin
        // The stale response is swallowed here without being pushed.
        if (mem_resp_valid) state_next = S_REQ;
      end
      default: ;
    endcase

    // Redirect overrides everything. If a request is still owed a response
    // after this cycle, that response must be dropped before re-issuing.
    if (redirect_valid) begin
      push_cnt = 2'd0;
      pc_next  = redirect_pc & ~ADDR_WIDTH'(3);
      if ((state_reg == S_REQ && handshake) ||
          ((state_reg == S_WAIT || state_reg == S_DRAIN) && !mem_resp_valid))
        state_next = S_DRAIN;
      else
        state_next = S_REQ;
    end

    count_next = redirect_valid ? '0
               : count_reg + CNT_W'(push_cnt) - CNT_W'(pop);
    free_next  = CNT_W'(FIFO_DEPTH) - count_next;
    // Request only when a full beat is guaranteed to fit.
    req_next   = (state_next == S_REQ) && (free_next >= CNT_W'(2));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg         <= S_REQ;
      pc_reg            <= RESET_PC;
      count_reg         <= '0;
      wr_ptr_reg        <= '0;
      rd_ptr_reg        <= '0;
      mem_req_valid_reg <= 1'b0;
      mem_req_addr_reg  <= '0;
      hold_instr_reg    <= '0;
      hold_pc_reg       <= '0;
    end else begin
      state_reg         <= state_next;
      pc_reg            <= pc_next;
      count_reg         <= count_next;
      mem_req_valid_reg <= req_next;
      if (req_next) mem_req_addr_reg <= pc_next & ~ADDR_WIDTH'(7);
      if (instr_valid && (pop || redirect_valid)) begin
        hold_instr_reg <= data_mem[rd_ptr_reg];
        hold_pc_reg    <= pc_mem[rd_ptr_reg];
      end
      if (redirect_valid) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(push_cnt);
        if (pop) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
    end
  end

  // Entry storage: up to two writes per cycle into consecutive slots.
  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (reset_n && push_cnt != 2'd0 && wr_ptr_reg == PTR_W'(gi)) begin
          data_mem[gi] <= word0;
          pc_mem[gi]   <= word0_pc;
        end else if (reset_n && push_cnt == 2'd2 && wr_ptr_plus1 == PTR_W'(gi)) begin
          data_mem[gi] <= word1;
          pc_mem[gi]   <= word1_pc;
        end
      end
    end
  endgenerate

endmodule
